// File: rtl/p2s_pkg.sv
// Shared types and helpers for the parallel-to-serial transmitter.
package p2s_pkg;

  // Transmit FSM: waiting for a word, or shifting one out.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } p2s_state_t;

  // Width of the bit counter for a given word width.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/p2s_hold_buf.sv
// One-entry holding buffer with a full flag.
// Ports:
//   clk, rst - clock and async active-high reset
//   load     - capture din and mark full
//   take     - release the held word (clears full)
//   din      - word to capture
//   dout     - held word
//   full     - buffer holds a word
module p2s_hold_buf
  import p2s_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             take,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full
);

  // Load wins over take; the transmitter never issues both together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      full <= 1'b0;
    end else if (load) begin
      dout <= din;
      full <= 1'b1;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/parallel_to_serial.sv
// Serializes width-bit words LSB first with a valid/ready bit stream and a
// one-word holding buffer so consecutive words stream without gaps.
// Ports:
//   clk, rst        - clock and async active-high reset
//   parallel_valid  - upstream offers parallel_data
//   parallel_data   - word to send, bit 0 first
//   parallel_ready  - a word can be accepted this cycle
//   serial_valid    - serial_data holds a valid bit
//   serial_data     - current bit
//   serial_last     - current bit is the word's MSB
//   serial_ready    - sink accepts the current bit
//   busy            - shifter or buffer holds data
module parallel_to_serial
  import p2s_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  input  logic [width-1:0] parallel_data,
  output logic             parallel_ready,
  output logic             serial_valid,
  output logic             serial_data,
  output logic             serial_last,
  input  logic             serial_ready,
  output logic             busy
);

  localparam int unsigned CW = cnt_width(width);
  localparam logic [CW-1:0] CNT_LAST = CW'(width - 1);

  p2s_state_t       state_q, state_d;
  logic [width-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] buf_data;
  logic             buf_full;
  logic             buf_load, buf_take;
  logic             rst_done_q;
  logic             hs, xfer, word_end;

  // Holds parallel_ready low during reset and releases it one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_done_q <= 1'b0;
    else     rst_done_q <= 1'b1;
  end

  assign parallel_ready = rst_done_q & ~buf_full;
  assign serial_valid   = (state_q == ST_SHIFT);
  assign serial_data    = sh_q[0];
  assign serial_last    = (state_q == ST_SHIFT) & (cnt_q == CNT_LAST);
  assign busy           = (state_q == ST_SHIFT) | buf_full;

  assign hs       = parallel_valid & parallel_ready;
  assign xfer     = (state_q == ST_SHIFT) & serial_ready;
  assign word_end = xfer & (cnt_q == CNT_LAST);

  p2s_hold_buf #(.width(width)) u_hold_buf (
    .clk  (clk),
    .rst  (rst),
    .load (buf_load),
    .take (buf_take),
    .din  (parallel_data),
    .dout (buf_data),
    .full (buf_full)
  );

  // State, shifter and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, shifter/counter update and buffer strobes.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    buf_load = 1'b0;
    buf_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          sh_d    = parallel_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (xfer && !word_end) begin
          sh_d  = sh_q >> 1;
          cnt_d = cnt_q + CW'(1);
        end else if (word_end) begin
          if (buf_full) begin
            // Buffered word takes over; ready is low so no handshake now.
            sh_d     = buf_data;
            cnt_d    = '0;
            buf_take = 1'b1;
          end else if (hs) begin
            // Bypass straight into the shifter: no bubble, buffer untouched.
            sh_d  = parallel_data;
            cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        // Any handshake not consumed by the bypass lands in the buffer.
        if (hs && !(word_end && !buf_full)) buf_load = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
module tb_parallel_to_serial;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         parallel_valid;
  logic [W-1:0] parallel_data;
  logic         parallel_ready;
  logic         serial_valid;
  logic         serial_data;
  logic         serial_last;
  logic         serial_ready;
  logic         busy;

  parallel_to_serial #(.width(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .parallel_valid (parallel_valid),
    .parallel_data  (parallel_data),
    .parallel_ready (parallel_ready),
    .serial_valid   (serial_valid),
    .serial_data    (serial_data),
    .serial_last    (serial_last),
    .serial_ready   (serial_ready),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: every accepted word contributes W bits, LSB first, to one stream.
  bit           exp_q[$];
  logic [W-1:0] rx_sh;
  int           rx_n;
  logic [W-1:0] rx_words[$];
  logic         last_hs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Words accepted but not fully sent: 2 means shifter plus buffer are occupied.
  function automatic int inflight();
    return (exp_q.size() + W - 1) / W;
  endfunction

  task automatic check_outputs();
    int l;
    l = exp_q.size();
    check_eq("serial_valid", 32'(serial_valid), 32'(l > 0));
    check_eq("busy", 32'(busy), 32'(l > 0));
    check_eq("parallel_ready", 32'(parallel_ready), 32'(inflight() < 2));
    if (l > 0) begin
      check_eq("serial_data", 32'(serial_data), 32'(exp_q[0]));
      check_eq("serial_last", 32'(serial_last), 32'((l % W) == 1));
    end else begin
      check_eq("serial_last_idle", 32'(serial_last), 32'(0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(serial_valid), 32'(0));
    check_eq({tag, "_data"},  32'(serial_data),  32'(0));
    check_eq({tag, "_last"},  32'(serial_last),  32'(0));
    check_eq({tag, "_busy"},  32'(busy),         32'(0));
    check_eq({tag, "_ready"}, 32'(parallel_ready), 32'(0));
  endtask

  // One clock cycle: check at negedge, drive, advance model at posedge.
  task automatic cycle(input logic pv, input logic [W-1:0] pd, input logic sr);
    logic xf, b, lst;
    check_outputs();
    parallel_valid = pv;
    parallel_data  = pd;
    serial_ready   = sr;
    last_hs = pv && (inflight() < 2);
    xf  = sr && (exp_q.size() > 0);
    b   = serial_data;
    lst = serial_last;
    @(posedge clk);
    if (xf) begin
      void'(exp_q.pop_front());
      rx_sh = {b, rx_sh[W-1:1]};
      rx_n++;
      if (lst) begin
        rx_words.push_back(rx_sh);
        rx_n = 0;
      end
    end
    if (last_hs) for (int k = 0; k < W; k++) exp_q.push_back(pd[k]);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [W-1:0] words[3];
    int           wi, run, nlast, rxc, budget;
    int           lpos[3];
    logic         ended, saw_nr;

    rst = 1'b0; parallel_valid = 1'b0; parallel_data = '0; serial_ready = 1'b0;
    rx_sh = '0; rx_n = 0; last_hs = 1'b0;

    // Reset then idle: async pulse mid-cycle.
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_assert");
    @(negedge clk);
    check_reset_outputs("rst_hold");
    #2 rst = 1'b0;
    #1 check_eq("ready_before_edge", 32'(parallel_ready), 32'(0));
    @(negedge clk);
    idle(3);

    // Single word 8'hA5.
    cycle(1'b1, 8'hA5, 1'b1);
    idle(9);
    check_eq("single_rx", 32'(rx_words[$]), 32'(8'hA5));
    check_eq("single_cnt", 32'(rx_words.size()), 32'(1));

    // Back-to-back 01, FF, 80 with parallel_valid held high.
    words[0] = 8'h01; words[1] = 8'hFF; words[2] = 8'h80;
    wi = 0; run = 0; nlast = 0; ended = 1'b0; saw_nr = 1'b0;
    lpos[0] = 0; lpos[1] = 0; lpos[2] = 0;
    for (int c = 0; c < 40; c++) begin
      if (serial_valid && !ended) begin
        run++;
        if (serial_last) begin
          if (nlast < 3) lpos[nlast] = run;
          nlast++;
        end
      end else if (run > 0) begin
        ended = 1'b1;
      end
      if (!parallel_ready) saw_nr = 1'b1;
      if (wi < 3) begin
        cycle(1'b1, words[wi], 1'b1);
        if (last_hs) wi++;
      end else begin
        cycle(1'b0, '0, 1'b1);
      end
    end
    check_eq("b2b_run", 32'(run), 32'(24));
    check_eq("b2b_nlast", 32'(nlast), 32'(3));
    check_eq("b2b_last0", 32'(lpos[0]), 32'(8));
    check_eq("b2b_last1", 32'(lpos[1]), 32'(16));
    check_eq("b2b_last2", 32'(lpos[2]), 32'(24));
    check_eq("b2b_ready_drop", 32'(saw_nr), 32'(1));
    check_eq("b2b_rx2", 32'(rx_words[$]), 32'(8'h80));

    // Backpressure: stall 5 cycles on bit 2 of 8'h3C.
    cycle(1'b1, 8'h3C, 1'b1);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_hold_data", 32'(serial_data), 32'(1));
      check_eq("bp_hold_last", 32'(serial_last), 32'(0));
      cycle(1'b0, '0, 1'b0);
    end
    idle(8);
    check_eq("bp_rx", 32'(rx_words[$]), 32'(8'h3C));

    // Bypass: 8'h55 handshaken on the last-bit transfer of 8'h0F.
    cycle(1'b1, 8'h0F, 1'b1);
    idle(7);
    check_eq("byp_on_last", 32'(serial_last), 32'(1));
    cycle(1'b1, 8'h55, 1'b1);
    check_eq("byp_hs", 32'(last_hs), 32'(1));
    check_eq("byp_bit0", 32'(serial_data), 32'(1));
    check_eq("byp_valid", 32'(serial_valid), 32'(1));
    check_eq("byp_no_buf", 32'(parallel_ready), 32'(1));
    idle(9);
    check_eq("byp_rx", 32'(rx_words[$]), 32'(8'h55));

    // Reset mid-word: 3 bits of 8'hC3 sent, 8'h5A buffered.
    cycle(1'b1, 8'hC3, 1'b1);
    cycle(1'b1, 8'h5A, 1'b1);
    idle(2);
    check_eq("rm_buffered", 32'(parallel_ready), 32'(0));
    rxc = rx_words.size();
    #2 rst = 1'b1;
    #1 check_reset_outputs("rm_assert");
    exp_q.delete();
    parallel_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("rm_hold");
    #2 rst = 1'b0;
    #1 check_eq("rm_ready_before_edge", 32'(parallel_ready), 32'(0));
    @(negedge clk);
    idle(20);
    check_eq("rm_no_word", 32'(rx_words.size()), 32'(rxc));
    rx_n = 0;

    // Randomized traffic and backpressure against the stream model.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), W'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    budget = 0;
    while (exp_q.size() > 0 && budget < 40) begin
      cycle(1'b0, '0, 1'b1);
      budget++;
    end
    check_eq("drain_done", 32'(exp_q.size()), 32'(0));
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
